boot_loader: RTL and testbench

- Upstream stage of core_fsm. Receives a byte stream from the host link (UART RX or debug bridge) and writes 32-bit little-endian words into instruction memory from BASE_ADDR.
- After the last word is written, pulses start for one cycle. core_fsm latches this pulse into active.
- One load per reset.

---
 rtl/boot_loader_pkg.sv | 16 +
 rtl/boot_loader_word_asm.sv | 33 +++
 rtl/boot_loader.sv | 156 +++++++++++++++
 tb/tb_boot_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared constants for boot_loader: FSM state codes and word geometry.
package boot_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t HDR  = 3'd0;
  localparam state_t DATA = 3'd1;
  localparam state_t CSUM = 3'd2;
  localparam state_t FIN  = 3'd3;
  localparam state_t DONE = 3'd4;
  localparam state_t ERR  = 3'd5;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

endpackage

// File: rtl/boot_loader_word_asm.sv
// Byte-to-word assembler: little-endian shift register with a lane counter and word_done strobe.
module boot_loader_word_asm
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [31:0]       word_r;
  logic [LANE_W-1:0] lane_r;

  // New bytes enter at the top so the first byte of a word ends up in [7:0].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_r <= 32'd0;
      lane_r <= 2'd0;
    end else if (shift_en) begin
      word_r <= word_next;
      lane_r <= lane_r + 2'd1;
    end else begin
      word_r <= word_r;
      lane_r <= lane_r;
    end
  end

  assign word_next = {din, word_r[31:8]};
  assign word_done = shift_en && (lane_r == LANE_W'(LANES - 1));

endmodule

// File: rtl/boot_loader.sv
// Host-stream boot loader: header word count, N little-endian words to memory, then a start pulse.
// Optional BOOT_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 4096
)(
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        start,
  output logic        busy,
  output logic        error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] sum_r;
`else
  localparam state_t TAIL = FIN;
`endif

  state_t      state_r, state_s;
  logic        live_r;
  logic        accept_s, shift_s, word_done_s;
  logic [31:0] word_next_s, n_r, idx_r;
  logic        mem_we_s, start_s, busy_s, error_s;
  logic [31:0] mem_addr_s, mem_wdata_s;
  logic        mem_we_r, start_r, busy_r, error_r;
  logic [31:0] mem_addr_r, mem_wdata_r;

  // live_r keeps rx_ready low while reset is asserted; DATA closes once every word is assembled.
  assign rx_ready = live_r && ((state_r == HDR) || (state_r == CSUM) ||
                               ((state_r == DATA) && (idx_r != n_r)));
  assign accept_s = rx_valid && rx_ready;
  assign shift_s  = accept_s && ((state_r == HDR) || (state_r == DATA));

  boot_loader_word_asm u_asm (
    .clk       (clk),
    .rstn      (rstn),
    .shift_en  (shift_s),
    .din       (rx_data),
    .word_next (word_next_s),
    .word_done (word_done_s)
  );

  // State register plus the header count, word index and running sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= HDR;
      live_r  <= 1'b0;
      n_r     <= 32'd0;
      idx_r   <= 32'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_r   <= 8'd0;
`endif
    end else begin
      state_r <= state_s;
      live_r  <= 1'b1;
      n_r     <= (state_r == HDR && word_done_s) ? word_next_s : n_r;
      idx_r   <= mem_we_s ? idx_r + 32'd1 : idx_r;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_r   <= shift_s ? sum_r + rx_data : sum_r;
`endif
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      HDR: begin
        if (word_done_s && (word_next_s > 32'(DEPTH_WORDS))) state_s = ERR;
        else if (word_done_s && (word_next_s == 32'd0))     state_s = TAIL;
        else if (word_done_s)                               state_s = DATA;
        else                                                state_s = HDR;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      DATA: begin
        if (word_done_s && (idx_r == n_r - 32'd1)) state_s = CSUM;
        else                                       state_s = DATA;
      end
      CSUM: begin
        if (accept_s && (rx_data == sum_r)) state_s = FIN;
        else if (accept_s)                  state_s = ERR;
        else                                state_s = CSUM;
      end
`else
      // Leave DATA during the final write cycle so start trails the last mem_we by one.
      DATA: begin
        if (idx_r == n_r) state_s = FIN;
        else              state_s = DATA;
      end
      CSUM:    state_s = ERR;
`endif
      FIN:     state_s = DONE;
      DONE:    state_s = DONE;
      ERR:     state_s = ERR;
      default: state_s = ERR;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    mem_we_s = word_done_s && (state_r == DATA);
    if (mem_we_s) begin
      mem_addr_s  = BASE_ADDR + {idx_r[29:0], 2'b00};
      mem_wdata_s = word_next_s;
    end else begin
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
    end
    start_s = (state_s == FIN);
    error_s = (state_s == ERR);
    case (state_s)
      HDR:     busy_s = busy_r || accept_s;
      DATA:    busy_s = 1'b1;
      CSUM:    busy_s = 1'b1;
      FIN:     busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= 32'd0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      start_r     <= start_s;
      busy_r      <= busy_s;
      error_r     <= error_s;
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign start     = start_r;
  assign busy      = busy_r;
  assign error     = error_r;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and random loads against a stream-level model.
module tb_boot_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 4096;

  logic        clk, rstn, rx_valid, rx_ready, mem_we, start, busy, error;
  logic [7:0]  rx_data;
  logic [31:0] mem_addr, mem_wdata;

  boot_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .start(start), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes and start pulses, sampled mid-cycle.
  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          start_cnt = 0;
  int          start_cyc = -1;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      w_addr.push_back(mem_addr);
      w_data.push_back(mem_wdata);
      w_cyc.push_back(cyc);
    end
    if (start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  logic [7:0]  stream[$];
  logic [31:0] wq[$];
  int          acc_q[$];

  task automatic build_stream(input logic [31:0] nf);
    int s;
    stream.delete();
    for (int b = 0; b < 4; b++) stream.push_back(8'(nf >> (8 * b)));
    foreach (wq[i]) for (int b = 0; b < 4; b++) stream.push_back(8'(wq[i] >> (8 * b)));
`ifdef BOOT_LOADER_CHECKSUM_EN
    s = 0;
    foreach (stream[i]) s += int'(stream[i]);
    stream.push_back(8'(s));
`endif
  endtask

  task automatic send_stream(input int count, input int maxgap);
    int k;
    bit ok;
    acc_q.delete();
    for (int i = 0; i < count; i++) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = stream[i];
      ok = 1'b0;
      k  = 0;
      while (!ok && k < 20) begin
        if (rx_ready === 1'b1) begin
          ok = 1'b1;
          acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        k++;
      end
      if (!ok) begin
        total++; bad++;
        $display("FAIL accept_timeout byte %0d: rx_ready stayed %b, required 1 within 20 cycles", i, rx_ready);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic drive_junk(input int cycles);
    rx_valid = 1'b1;
    repeat (cycles) begin
      rx_data = 8'($urandom());
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    start_cnt = 0;
    start_cyc = -1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    total += 7;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
    if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    if (mem_addr !== BASE) begin bad++; $display("FAIL reset_mem_addr got %h want %h", mem_addr, BASE); end
    if (mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    if (start !== 1'b0) begin bad++; $display("FAIL reset_start got %b want 0", start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (error !== 1'b0) begin bad++; $display("FAIL reset_error got %b want 0", error); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Full load of wq: writes, write timing, one start at the right cycle, clean DONE.
  task automatic test_load(input string name, input int maxgap);
    int n, last, exp_start, nw;
    bit cs;
`ifdef BOOT_LOADER_CHECKSUM_EN
    cs = 1'b1;
`else
    cs = 1'b0;
`endif
    n = wq.size();
    build_stream(32'(n));
    send_stream(stream.size(), maxgap);
    repeat (4) @(negedge clk);
    last = (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : -100;
    exp_start = (n == 0 || cs) ? last : last + 1;
    total++;
    if (w_addr.size() != n) begin bad++; $display("FAIL %s write_count got %0d want %0d", name, w_addr.size(), n); end
    nw = (w_addr.size() < n) ? w_addr.size() : n;
    for (int i = 0; i < nw; i++) begin
      total += 3;
      if (w_addr[i] !== BASE + 32'(4 * i)) begin bad++; $display("FAIL %s addr[%0d] got %h want %h", name, i, w_addr[i], BASE + 32'(4 * i)); end
      if (w_data[i] !== wq[i]) begin bad++; $display("FAIL %s data[%0d] got %h want %h", name, i, w_data[i], wq[i]); end
      if (acc_q.size() > 4 * i + 7 && w_cyc[i] != acc_q[4 * i + 7]) begin
        bad++; $display("FAIL %s write_cycle[%0d] got %0d want %0d", name, i, w_cyc[i], acc_q[4 * i + 7]);
      end
    end
    total += 5;
    if (start_cnt != 1) begin bad++; $display("FAIL %s start_count got %0d want 1", name, start_cnt); end
    if (start_cyc != exp_start) begin bad++; $display("FAIL %s start_cycle got %0d want %0d", name, start_cyc, exp_start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    if (error !== 1'b0) begin bad++; $display("FAIL %s error_after got %b want 0", name, error); end
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL %s rx_ready_done got %b want 0", name, rx_ready); end
    drive_junk(6);
    repeat (2) @(negedge clk);
    total += 2;
    if (w_addr.size() != n) begin bad++; $display("FAIL %s done_ignores_writes got %0d want %0d", name, w_addr.size(), n); end
    if (start_cnt != 1) begin bad++; $display("FAIL %s done_ignores_start got %0d want 1", name, start_cnt); end
  endtask

  task automatic test_basic();
    wq = '{32'h0000_0013, 32'h0000_006F};
    test_load("basic", 0);
  endtask

  task automatic test_gaps();
    wq = '{32'h0000_0013, 32'h0000_006F};
    test_load("gaps", 5);
  endtask

  task automatic test_zero();
    wq.delete();
    test_load("zero", 0);
  endtask

  task automatic test_overflow();
    stream = '{8'h01, 8'h10, 8'h00, 8'h00};
    send_stream(4, 0);
    repeat (3) @(negedge clk);
    drive_junk(10);
    repeat (3) @(negedge clk);
    total += 5;
    if (error !== 1'b1) begin bad++; $display("FAIL overflow_error got %b want 1", error); end
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL overflow_rx_ready got %b want 0", rx_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL overflow_busy got %b want 0", busy); end
    if (w_addr.size() != 0) begin bad++; $display("FAIL overflow_writes got %0d want 0", w_addr.size()); end
    if (start_cnt != 0) begin bad++; $display("FAIL overflow_start got %0d want 0", start_cnt); end
  endtask

  task automatic test_reset_midload();
    wq = '{32'h0000_0013, 32'h0000_006F};
    build_stream(32'd2);
    send_stream(6, 0);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL midload_busy got %b want 1", busy); end
    if (w_addr.size() != 0) begin bad++; $display("FAIL midload_writes got %0d want 0", w_addr.size()); end
    rstn = 1'b0;
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL midload_abort_busy got %b want 0", busy); end
    if (mem_addr !== BASE) begin bad++; $display("FAIL midload_abort_addr got %h want %h", mem_addr, BASE); end
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL midload_abort_ready got %b want 0", rx_ready); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    start_cnt = 0;
    start_cyc = -1;
    wq = '{32'hDEAD_BEEF};
    test_load("after_reset", 0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      n = int'($urandom_range(6, 1));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom());
      test_load("random", 3);
    end
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    wq = '{32'h0000_0013};
    build_stream(32'd1);
    stream[stream.size() - 1] = stream[stream.size() - 1] + 8'd1;
    send_stream(stream.size(), 0);
    repeat (4) @(negedge clk);
    total += 4;
    if (stream[stream.size() - 1] !== 8'h15) begin bad++; $display("FAIL csum_byte got %h want 15", stream[stream.size() - 1]); end
    if (error !== 1'b1) begin bad++; $display("FAIL csum_error got %b want 1", error); end
    if (start_cnt != 0) begin bad++; $display("FAIL csum_start got %0d want 0", start_cnt); end
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL csum_rx_ready got %b want 0", rx_ready); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    test_reset();
    test_basic();
    do_reset();
    test_gaps();
    do_reset();
    test_zero();
    do_reset();
    test_overflow();
    do_reset();
    test_reset_midload();
    test_random();
`ifdef BOOT_LOADER_CHECKSUM_EN
    do_reset();
    wq = '{32'h0000_0013};
    test_load("csum_good", 0);
    do_reset();
    test_checksum_bad();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
